// File: rtl/cntr_sweep_ctrl.sv
// cntr_sweep_ctrl: command-driven ping-pong sweep sequencer for an up/down count.
// A host hands over bounds, start direction and pass count through a valid/ready
// handshake; the block walks q between the bounds, optionally dwelling at each
// turning point, and pulses done when the last pass ends or the sweep is aborted.
module cntr_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int DWELL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic [7:0]       cmd_passes,
    input  logic             cmd_up_first,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             ud,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DWELL_ST = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The dwell counter is loaded with DWELL-1 so that the DWELL state lasts exactly DWELL cycles.
    localparam logic [7:0] DWELL_LOAD = (DWELL > 0) ? 8'(DWELL - 1) : 8'd0;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             ud_n;
    logic [WIDTH-1:0] lo_r, lo_n;
    logic [WIDTH-1:0] hi_r, hi_n;
    logic [7:0]       pass_cnt, pass_n;
    logic [7:0]       dwell_cnt, dwell_n;
    logic             err_n;
    logic [WIDTH-1:0] end_val;

    // State and datapath registers; reset is synchronous and clears everything, no done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            q         <= '0;
            ud        <= 1'b0;
            lo_r      <= '0;
            hi_r      <= '0;
            pass_cnt  <= 8'd0;
            dwell_cnt <= 8'd0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            q         <= q_n;
            ud        <= ud_n;
            lo_r      <= lo_n;
            hi_r      <= hi_n;
            pass_cnt  <= pass_n;
            dwell_cnt <= dwell_n;
            err       <= err_n;
        end
    end

    // Next-state logic: command acceptance, stepping, turning, dwelling and abort.
    always_comb begin
        state_n   = state;
        q_n       = q;
        ud_n      = ud;
        lo_n      = lo_r;
        hi_n      = hi_r;
        pass_n    = pass_cnt;
        dwell_n   = dwell_cnt;
        err_n     = 1'b0;
        end_val   = ud ? lo_r : hi_r;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_lo > cmd_hi) || (cmd_passes == 8'd0)) begin
                        err_n = 1'b1;
                    end else begin
                        lo_n    = cmd_lo;
                        hi_n    = cmd_hi;
                        pass_n  = cmd_passes;
                        q_n     = cmd_up_first ? cmd_lo : cmd_hi;
                        ud_n    = !cmd_up_first;
                        state_n = SWEEP;
                    end
                end
            end
            SWEEP: begin
                if (stop) begin
                    pass_n  = 8'd0;
                    state_n = DONE;
                end else if (q != end_val) begin
                    q_n = ud ? (q - WIDTH'(1)) : (q + WIDTH'(1));
                end else if (pass_cnt == 8'd1) begin
                    pass_n  = 8'd0;
                    state_n = DONE;
                end else begin
                    pass_n = pass_cnt - 8'd1;
                    ud_n   = !ud;
                    if (DWELL > 0) begin
                        dwell_n = DWELL_LOAD;
                        state_n = DWELL_ST;
                    end
                end
            end
            DWELL_ST: begin
                if (stop) begin
                    pass_n  = 8'd0;
                    dwell_n = 8'd0;
                    state_n = DONE;
                end else if (dwell_cnt == 8'd0) begin
                    state_n = SWEEP;
                end else begin
                    dwell_n = dwell_cnt - 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cntr_sweep_ctrl.sv
// tb_cntr_sweep_ctrl: directed bench for cntr_sweep_ctrl.
// Two instances share the command inputs: dut_a turns immediately (DWELL=0),
// dut_b dwells two cycles at each turning point (DWELL=2).
module tb_cntr_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [3:0] cmd_lo;
    logic [3:0] cmd_hi;
    logic [7:0] cmd_passes;
    logic       cmd_up_first;
    logic       stop;

    logic       a_ready, a_ud, a_busy, a_done, a_err;
    logic [3:0] a_q;
    logic       b_ready, b_ud, b_busy, b_done, b_err;
    logic [3:0] b_q;

    int vectors;
    int miscompares;

    cntr_sweep_ctrl #(.WIDTH(4), .DWELL(0)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_passes(cmd_passes),
        .cmd_up_first(cmd_up_first), .stop(stop), .q(a_q), .ud(a_ud),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    cntr_sweep_ctrl #(.WIDTH(4), .DWELL(2)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_passes(cmd_passes),
        .cmd_up_first(cmd_up_first), .stop(stop), .q(b_q), .ud(b_ud),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-derived expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one command for a single cycle; returns in the cycle after the handshake edge.
    task automatic applyStimulus(input logic [3:0] lo, input logic [3:0] hi,
                                 input logic [7:0] passes, input logic up);
        cmd_lo       = lo;
        cmd_hi       = hi;
        cmd_passes   = passes;
        cmd_up_first = up;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
        cmd_lo       = 4'd0;
        cmd_hi       = 4'd0;
        cmd_passes   = 8'd0;
    endtask

    // Wait (bounded) until both instances are back in IDLE.
    task automatic waitIdle(input string tag);
        for (int n = 0; n < 500; n++) begin
            if (!a_busy && !b_busy) break;
            tick();
        end
        checkOutput(tag, {30'd0, a_busy, b_busy}, 32'd0);
    endtask

    // Directed sequence.
    initial begin
        logic [3:0] expq[$];
        logic       expud[$];
        logic [3:0] seq_q[8];
        logic       seq_ud[8];

        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_lo       = 4'd0;
        cmd_hi       = 4'd0;
        cmd_passes   = 8'd0;
        cmd_up_first = 1'b0;
        stop         = 1'b0;

        tick();
        tick();
        reset = 1'b1;
        checkOutput("rst_q", a_q, 0);
        checkOutput("rst_ud", a_ud, 0);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_done", a_done, 0);
        checkOutput("rst_err", a_err, 0);
        checkOutput("rst_ready", a_ready, 1);
        checkOutput("rst_b_busy", b_busy, 0);

        // Single up pass 2..5.
        applyStimulus(4'd2, 4'd5, 8'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_q", a_q, 2 + i);
            checkOutput("t1_ud", a_ud, 0);
            checkOutput("t1_busy", a_busy, 1);
            checkOutput("t1_done_lo", a_done, 0);
            checkOutput("t1_b_q", b_q, 2 + i);
            tick();
        end
        checkOutput("t1_done", a_done, 1);
        checkOutput("t1_done_q", a_q, 5);
        checkOutput("t1_ready_lo", a_ready, 0);
        checkOutput("t1_b_done", b_done, 1);
        tick();
        checkOutput("t1_ready", a_ready, 1);
        checkOutput("t1_done_clr", a_done, 0);
        checkOutput("t1_idle_q", a_q, 5);

        // Three full-range passes, no wrap at either end.
        applyStimulus(4'd0, 4'd15, 8'd3, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v < 16; v++) begin
                expq.push_back((p % 2 == 0) ? 4'(v) : 4'(15 - v));
                expud.push_back(p % 2 == 1);
            end
        end
        foreach (expq[i]) begin
            checkOutput("t2_q", a_q, expq[i]);
            checkOutput("t2_ud", a_ud, expud[i]);
            checkOutput("t2_done_lo", a_done, 0);
            tick();
        end
        checkOutput("t2_done", a_done, 1);
        checkOutput("t2_done_q", a_q, 15);
        waitIdle("t2_idle_timeout");

        // Two passes starting downward with a two-cycle dwell at the bottom.
        seq_q  = '{4'd6, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd6};
        seq_ud = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(4'd4, 4'd6, 8'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t3_q", b_q, seq_q[i]);
            checkOutput("t3_ud", b_ud, seq_ud[i]);
            checkOutput("t3_done_lo", b_done, 0);
            tick();
        end
        checkOutput("t3_done", b_done, 1);
        checkOutput("t3_done_q", b_q, 6);
        checkOutput("t3_done_ud", b_ud, 0);
        waitIdle("t3_idle_timeout");

        // Rejected commands: inverted bounds, then zero passes.
        applyStimulus(4'd9, 4'd3, 8'd1, 1'b1);
        checkOutput("t4a_err", a_err, 1);
        checkOutput("t4a_busy", a_busy, 0);
        checkOutput("t4a_q", a_q, 6);
        tick();
        checkOutput("t4a_err_clr", a_err, 0);
        checkOutput("t4a_busy2", a_busy, 0);
        applyStimulus(4'd3, 4'd9, 8'd0, 1'b1);
        checkOutput("t4b_err", a_err, 1);
        checkOutput("t4b_busy", a_busy, 0);
        tick();
        checkOutput("t4b_err_clr", a_err, 0);
        checkOutput("t4b_busy2", a_busy, 0);
        checkOutput("t4b_q", a_q, 6);

        // Abort at q==7 in a full-range sweep.
        applyStimulus(4'd0, 4'd15, 8'd1, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("t5_q7", a_q, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("t5_done", a_done, 1);
        checkOutput("t5_q", a_q, 7);
        checkOutput("t5_busy", a_busy, 1);
        checkOutput("t5_b_done", b_done, 1);
        checkOutput("t5_b_q", b_q, 7);
        tick();
        checkOutput("t5_idle", a_busy, 0);
        checkOutput("t5_done_clr", a_done, 0);
        checkOutput("t5_idle_q", a_q, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("t5_stop_idle_busy", a_busy, 0);
        checkOutput("t5_stop_idle_done", a_done, 0);
        applyStimulus(4'd1, 4'd2, 8'd1, 1'b0);
        checkOutput("t5_next_q", a_q, 2);
        checkOutput("t5_next_ud", a_ud, 1);
        tick();
        checkOutput("t5_next_q2", a_q, 1);
        tick();
        checkOutput("t5_next_done", a_done, 1);
        tick();

        // Reset while dut_b dwells, then a lo==hi sweep.
        applyStimulus(4'd4, 4'd6, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t6_dwell_q", b_q, 4);
        checkOutput("t6_dwell_ud", b_ud, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("t6_rst_q", b_q, 0);
        checkOutput("t6_rst_ud", b_ud, 0);
        checkOutput("t6_rst_busy", b_busy, 0);
        checkOutput("t6_rst_done", b_done, 0);
        checkOutput("t6_rst_a_busy", a_busy, 0);
        tick();
        checkOutput("t6_no_done", b_done, 0);
        applyStimulus(4'd5, 4'd5, 8'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t6_q", a_q, 5);
            checkOutput("t6_ud", a_ud, i % 2);
            checkOutput("t6_busy", a_busy, 1);
            checkOutput("t6_done_lo", a_done, 0);
            tick();
        end
        checkOutput("t6_done", a_done, 1);
        checkOutput("t6_done_q", a_q, 5);
        waitIdle("t6_idle_timeout");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
